// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared op, currency, status and FSM encodings for atm_ledger
package atm_pkg;

  typedef enum logic [1:0] {
    OP_SHOW     = 2'd0,
    OP_WITHDRAW = 2'd1,
    OP_TRANSFER = 2'd2,
    OP_CONVERT  = 2'd3
  } op_e;

  localparam int CUR_USD = 0;
  localparam int CUR_BTC = 1;
  localparam int CUR_ETH = 2;
  localparam int CUR_XRP = 3;
  localparam int CUR_LTC = 4;

  localparam logic [3:0] ST_OK            = 4'h5;
  localparam logic [3:0] ST_ACC_NOT_FOUND = 4'h2;
  localparam logic [3:0] ST_AMT_INVALID   = 4'h6;
  localparam logic [3:0] ST_CUR_INVALID   = 4'h9;
  localparam logic [3:0] ST_RATE_INVALID  = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/atm_rate_conv.sv
// rtl/atm_rate_conv.sv - fixed-point currency conversion with destination overflow flag
module atm_rate_conv #(
  parameter int BAL_W     = 16,
  parameter int RATE_W    = 32,
  parameter int RATE_FRAC = 12
) (
  input  logic [BAL_W-1:0]  i_amt,
  input  logic [RATE_W-1:0] i_rate,
  input  logic [BAL_W-1:0]  i_dst_bal,
  output logic [BAL_W-1:0]  o_credit,
  output logic              o_ovf
);

  logic [BAL_W+RATE_W-1:0] w_prod;
  logic [BAL_W+RATE_W-1:0] w_full;
  logic [BAL_W:0]          w_sum;

  assign w_prod   = {{RATE_W{1'b0}}, i_amt} * {{BAL_W{1'b0}}, i_rate};
  assign w_full   = w_prod >> RATE_FRAC;
  assign o_credit = w_full[BAL_W-1:0];
  assign w_sum    = {1'b0, i_dst_bal} + {1'b0, o_credit};
  // Overflow if the credit alone exceeds a balance, or it does once added.
  assign o_ovf    = (|w_full[BAL_W+RATE_W-1:BAL_W]) | w_sum[BAL_W];

endmodule

// File: rtl/atm_ledger.sv
// rtl/atm_ledger.sv - multi-account, multi-currency ledger with request/response engine
module atm_ledger
  import atm_pkg::*;
#(
  parameter int N_ACC     = 10,
  parameter int N_CUR     = 5,
  parameter int BAL_W     = 16,
  parameter int RATE_W    = 32,
  parameter int RATE_FRAC = 12,
  parameter int INIT_BAL0 = 500,
  parameter int INIT_BAL  = 10,
  parameter int ACC_W     = $clog2(N_ACC),
  parameter int CUR_W     = $clog2(N_CUR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ACC_W-1:0]  req_acc,
  input  logic [ACC_W-1:0]  req_dst_acc,
  input  logic [CUR_W-1:0]  req_cur,
  input  logic [CUR_W-1:0]  req_cur2,
  input  logic [BAL_W-1:0]  req_amt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_status,
  output logic [BAL_W-1:0]  rsp_bal,
  input  logic              rate_we,
  input  logic [CUR_W-1:0]  rate_src,
  input  logic [CUR_W-1:0]  rate_dst,
  input  logic [RATE_W-1:0] rate_val
);

  localparam logic [ACC_W:0] L_NACC = (ACC_W+1)'(N_ACC);
  localparam logic [CUR_W:0] L_NCUR = (CUR_W+1)'(N_CUR);

  state_e            r_state;
  op_e               r_op;
  logic [ACC_W-1:0]  r_acc, r_dst;
  logic [CUR_W-1:0]  r_cur, r_cur2;
  logic [BAL_W-1:0]  r_amt, r_credit;
  logic [3:0]        r_status;
  logic [BAL_W-1:0]  r_bal  [N_ACC][N_CUR];
  logic [RATE_W-1:0] r_rate [N_CUR][N_CUR];

  logic              w_acc_ok, w_dst_ok, w_cur_ok, w_cur2_ok, w_rsrc_ok, w_rdst_ok;
  logic [ACC_W-1:0]  w_sa, w_sd;
  logic [CUR_W-1:0]  w_sc, w_sc2;
  logic [BAL_W-1:0]  w_src_bal, w_xdst_bal, w_cdst_bal, w_credit;
  logic [RATE_W-1:0] w_rate;
  logic [BAL_W:0]    w_xfer_sum;
  logic              w_conv_ovf;
  logic [3:0]        w_status;

  assign req_ready = (r_state == S_IDLE);

  assign w_acc_ok  = {1'b0, r_acc}    < L_NACC;
  assign w_dst_ok  = {1'b0, r_dst}    < L_NACC;
  assign w_cur_ok  = {1'b0, r_cur}    < L_NCUR;
  assign w_cur2_ok = {1'b0, r_cur2}   < L_NCUR;
  assign w_rsrc_ok = {1'b0, rate_src} < L_NCUR;
  assign w_rdst_ok = {1'b0, rate_dst} < L_NCUR;

  // Clamp indices so array reads stay in range; status gates any use of them.
  assign w_sa  = w_acc_ok  ? r_acc  : '0;
  assign w_sd  = w_dst_ok  ? r_dst  : '0;
  assign w_sc  = w_cur_ok  ? r_cur  : '0;
  assign w_sc2 = w_cur2_ok ? r_cur2 : '0;

  assign w_src_bal  = r_bal[w_sa][w_sc];
  assign w_xdst_bal = r_bal[w_sd][w_sc];
  assign w_cdst_bal = r_bal[w_sa][w_sc2];
  assign w_rate     = r_rate[w_sc][w_sc2];
  assign w_xfer_sum = {1'b0, w_xdst_bal} + {1'b0, r_amt};

  atm_rate_conv #(
    .BAL_W    (BAL_W),
    .RATE_W   (RATE_W),
    .RATE_FRAC(RATE_FRAC)
  ) u_conv (
    .i_amt    (r_amt),
    .i_rate   (w_rate),
    .i_dst_bal(w_cdst_bal),
    .o_credit (w_credit),
    .o_ovf    (w_conv_ovf)
  );

  always_comb begin
    w_status = ST_OK;
    if (!w_acc_ok || (r_op == OP_TRANSFER && !w_dst_ok))
      w_status = ST_ACC_NOT_FOUND;
    else if (!w_cur_ok || (r_op == OP_CONVERT && !w_cur2_ok))
      w_status = ST_CUR_INVALID;
    else if (r_op == OP_CONVERT && (r_cur == r_cur2 || w_rate == '0))
      w_status = ST_RATE_INVALID;
    else if (r_op != OP_SHOW && r_amt > w_src_bal)
      w_status = ST_AMT_INVALID;
    else if (r_op == OP_TRANSFER && r_acc != r_dst && w_xfer_sum[BAL_W])
      w_status = ST_AMT_INVALID;
    else if (r_op == OP_CONVERT && w_conv_ovf)
      w_status = ST_AMT_INVALID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= OP_SHOW;
      r_acc      <= '0;
      r_dst      <= '0;
      r_cur      <= '0;
      r_cur2     <= '0;
      r_amt      <= '0;
      r_credit   <= '0;
      r_status   <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_bal    <= '0;
      for (int a = 0; a < N_ACC; a++)
        for (int c = 0; c < N_CUR; c++)
          r_bal[a][c] <= (c == 0) ? BAL_W'(INIT_BAL0) : BAL_W'(INIT_BAL);
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_op    <= op_e'(req_op);
          r_acc   <= req_acc;
          r_dst   <= req_dst_acc;
          r_cur   <= req_cur;
          r_cur2  <= req_cur2;
          r_amt   <= req_amt;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_status <= w_status;
          r_credit <= w_credit;
          r_state  <= S_COMMIT;
        end
        S_COMMIT: begin
          if (r_status == ST_OK) begin
            case (r_op)
              OP_WITHDRAW: r_bal[w_sa][w_sc] <= w_src_bal - r_amt;
              OP_TRANSFER: if (r_acc != r_dst) begin
                r_bal[w_sa][w_sc] <= w_src_bal - r_amt;
                r_bal[w_sd][w_sc] <= w_xdst_bal + r_amt;
              end
              OP_CONVERT: begin
                r_bal[w_sa][w_sc]  <= w_src_bal - r_amt;
                r_bal[w_sa][w_sc2] <= w_cdst_bal + r_credit;
              end
              default: ;
            endcase
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (!rsp_valid) begin
            rsp_valid  <= 1'b1;
            rsp_status <= r_status;
            rsp_bal    <= (w_acc_ok && w_cur_ok) ? w_src_bal : '0;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N_CUR; s++)
        for (int d = 0; d < N_CUR; d++)
          r_rate[s][d] <= (s == d) ? (RATE_W'(1) << RATE_FRAC) : '0;
    end else if (rate_we && w_rsrc_ok && w_rdst_ok) begin
      r_rate[rate_src][rate_dst] <= rate_val;
    end
  end

endmodule

// File: tb/tb_atm_ledger.sv
// tb/tb_atm_ledger.sv - directed scoreboard bench for atm_ledger
module tb_atm_ledger;
  import atm_pkg::*;

  localparam int ACC_W = 4;
  localparam int CUR_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [ACC_W-1:0] req_acc = '0, req_dst_acc = '0;
  logic [CUR_W-1:0] req_cur = '0, req_cur2 = '0;
  logic [15:0] req_amt = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_status;
  logic [15:0] rsp_bal;
  logic        rate_we = 1'b0;
  logic [CUR_W-1:0] rate_src = '0, rate_dst = '0;
  logic [31:0] rate_val = '0;

  typedef struct {
    logic [3:0]  status;
    logic [15:0] bal;
    bit          cbal;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_fail  = 0;

  atm_ledger dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acc(req_acc), .req_dst_acc(req_dst_acc), .req_cur(req_cur),
    .req_cur2(req_cur2), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_bal(rsp_bal),
    .rate_we(rate_we), .rate_src(rate_src), .rate_dst(rate_dst), .rate_val(rate_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_status"}, 32'(rsp_status), 0);
    chk({tag, "_rsp_bal"}, 32'(rsp_bal), 0);
  endtask

  task automatic set_rate(input int s, input int d, input logic [31:0] v);
    @(negedge clk);
    rate_we = 1'b1; rate_src = CUR_W'(s); rate_dst = CUR_W'(d); rate_val = v;
    @(posedge clk);
    #1 rate_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request; optionally poke a rate write onto the CHECK edge and hold rsp_ready low.
  task automatic run_req(input string tag, input op_e op, input int acc, input int dst,
                         input int cur, input int cur2, input int amt,
                         input logic [3:0] est, input int ebal, input bit cbal,
                         input bit rate_poke, input int hold);
    exp_t e;
    exp_t got_e;
    int   n;
    e.status = est; e.bal = 16'(ebal); e.cbal = cbal; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_acc = ACC_W'(acc); req_dst_acc = ACC_W'(dst);
    req_cur = CUR_W'(cur); req_cur2 = CUR_W'(cur2); req_amt = 16'(amt);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (rate_poke) begin
      rate_we = 1'b1; rate_src = CUR_W'(cur); rate_dst = CUR_W'(cur2); rate_val = 32'd4096;
    end
    @(posedge clk);
    #1 rate_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_lat_early"}, 32'(rsp_valid), 0);
    @(negedge clk);
    chk({tag, "_lat"}, 32'(rsp_valid), 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      got_e = sb.pop_front();
      chk({got_e.tag, "_status"}, 32'(rsp_status), 32'(got_e.status));
      if (got_e.cbal) chk({got_e.tag, "_bal"}, 32'(rsp_bal), 32'(got_e.bal));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({got_e.tag, "_hold_valid"}, 32'(rsp_valid), 1);
        chk({got_e.tag, "_hold_status"}, 32'(rsp_status), 32'(got_e.status));
        chk({got_e.tag, "_hold_bal"}, 32'(rsp_bal), 32'(got_e.bal));
        chk({got_e.tag, "_hold_ready"}, 32'(req_ready), 0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, "_done"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    #1;
    chk_idle_reset("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_reset("reset");

    run_req("show_a3",   OP_SHOW,     3, 0, CUR_USD, 0, 0,   ST_OK,          500, 1, 0, 0);
    run_req("wd_500",    OP_WITHDRAW, 0, 0, CUR_USD, 0, 500, ST_OK,          0,   1, 0, 0);
    run_req("wd_1",      OP_WITHDRAW, 0, 0, CUR_USD, 0, 1,   ST_AMT_INVALID, 0,   1, 0, 0);

    do_reset();
    run_req("xfer_0_1",  OP_TRANSFER, 0, 1, CUR_USD, 0, 500, ST_OK,          0,    1, 0, 0);
    run_req("show_a1",   OP_SHOW,     1, 0, CUR_USD, 0, 0,   ST_OK,          1000, 1, 0, 0);
    run_req("xfer_dst12",OP_TRANSFER, 0, 12, CUR_USD, 0, 1,  ST_ACC_NOT_FOUND, 0,  1, 0, 0);
    run_req("xfer_self", OP_TRANSFER, 1, 1, CUR_USD, 0, 100, ST_OK,          1000, 1, 0, 0);

    set_rate(CUR_USD, CUR_XRP, 32'd7127);
    run_req("conv_usd_xrp", OP_CONVERT, 2, 0, CUR_USD, CUR_XRP, 100, ST_OK,   400, 1, 0, 0);
    run_req("show_xrp",  OP_SHOW,     2, 0, CUR_XRP, 0, 0,   ST_OK,          183, 1, 0, 0);

    set_rate(CUR_BTC, CUR_USD, 32'd76943360);
    run_req("conv_ovf",  OP_CONVERT,  2, 0, CUR_BTC, CUR_USD, 5, ST_AMT_INVALID, 10, 1, 0, 0);
    run_req("show_usd",  OP_SHOW,     2, 0, CUR_USD, 0, 0,   ST_OK,          400, 1, 0, 0);
    run_req("conv_poke", OP_CONVERT,  2, 0, CUR_ETH, CUR_LTC, 1, ST_RATE_INVALID, 10, 1, 1, 0);
    run_req("conv_eth",  OP_CONVERT,  2, 0, CUR_ETH, CUR_LTC, 10, ST_OK,     0,   1, 0, 0);
    run_req("show_ltc",  OP_SHOW,     2, 0, CUR_LTC, 0, 0,   ST_OK,          20,  1, 0, 0);
    run_req("conv_same", OP_CONVERT,  2, 0, CUR_USD, CUR_USD, 1, ST_RATE_INVALID, 400, 1, 0, 0);
    run_req("show_cur6", OP_SHOW,     2, 0, 6, 0, 0,         ST_CUR_INVALID, 0,   0, 0, 0);
    run_req("wd_acc11",  OP_WITHDRAW, 11, 0, CUR_USD, 0, 1,  ST_ACC_NOT_FOUND, 0, 0, 0, 0);
    run_req("hold",      OP_SHOW,     2, 0, CUR_XRP, 0, 0,   ST_OK,          183, 1, 0, 5);

    @(negedge clk);
    req_valid = 1'b1; req_op = OP_WITHDRAW; req_acc = 4'd2; req_cur = 3'(CUR_USD); req_amt = 16'd100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_reset("rst_commit");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_commit_no_rsp", 32'(rsp_valid), 0);

    run_req("post_usd",  OP_SHOW,     2, 0, CUR_USD, 0, 0,   ST_OK,          500, 1, 0, 0);
    run_req("post_xrp",  OP_SHOW,     2, 0, CUR_XRP, 0, 0,   ST_OK,          10,  1, 0, 0);
    run_req("post_a1",   OP_SHOW,     1, 0, CUR_USD, 0, 0,   ST_OK,          500, 1, 0, 0);
    run_req("post_rate", OP_CONVERT,  2, 0, CUR_USD, CUR_XRP, 100, ST_RATE_INVALID, 500, 1, 0, 0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
